// File: rtl/lsu_bus_host_if.sv
// Avalon-MM read/write bus between one host and the memory agents.
// Host drives the command side; the agent returns read data and handshakes.
interface AvalonMmRw #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   host_to_agent;
  logic [DATA_W-1:0]   agent_to_host;
  logic                waitrequest;
  logic                readdatavalid;

  modport Host (
    output address, read, write, byteenable, host_to_agent,
    input  agent_to_host, waitrequest, readdatavalid
  );

  modport Agent (
    input  address, read, write, byteenable, host_to_agent,
    output agent_to_host, waitrequest, readdatavalid
  );
endinterface

// File: rtl/lsu_bus_host.sv
// Single-outstanding load/store bus initiator: lane steering, load extension,
// misalignment rejection and a strobe timeout.
module lsu_bus_host #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  AvalonMmRw.Host     bus
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_e;

  state_e            state_q, state_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [31:0]       address_q, address_d;
  logic [3:0]        byteenable_q, byteenable_d;
  logic [31:0]       h2a_q, h2a_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              timeout_hit;

  function automatic logic access_bad(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] base;
    case (size)
      2'b00:   base = 4'b0001;
      2'b01:   base = 4'b0011;
      default: base = 4'b1111;
    endcase
    return base << off;
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [1:0] off,
                                              input logic [1:0] size, input logic uns);
    logic [31:0] lane;
    lane = raw >> {off, 3'b000};
    case (size)
      2'b00:   return uns ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      2'b01:   return uns ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: return lane;
    endcase
  endfunction

  // The counter holds the number of unanswered strobe cycles seen so far;
  // the strobe drops on the cycle that would bring it up to TIMEOUT.
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == TO_VAL);

  always_comb begin
    state_d      = state_q;
    read_d       = read_q;
    write_d      = write_q;
    address_d    = address_q;
    byteenable_d = byteenable_q;
    h2a_d        = h2a_q;
    off_d        = off_q;
    size_d       = size_q;
    uns_d        = uns_q;
    cnt_d        = cnt_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (access_bad(req_size, req_addr[1:0])) begin
            state_d     = S_RESP;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'b0;
          end else begin
            address_d    = {req_addr[31:2], 2'b00};
            byteenable_d = lane_mask(req_size, req_addr[1:0]);
            h2a_d        = req_wdata << {req_addr[1:0], 3'b000};
            off_d        = req_addr[1:0];
            size_d       = req_size;
            uns_d        = req_unsigned;
            cnt_d        = '0;
            read_d       = !req_write;
            write_d      = req_write;
            state_d      = req_write ? S_WRITE : S_READ;
          end
        end
      end
      S_READ: begin
        if (bus.readdatavalid) begin
          read_d      = 1'b0;
          rsp_rdata_d = extend_load(bus.agent_to_host, off_q, size_q, uns_q);
          rsp_err_d   = 1'b0;
          state_d     = S_RESP;
        end else if (timeout_hit) begin
          read_d      = 1'b0;
          rsp_rdata_d = 32'b0;
          rsp_err_d   = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WRITE: begin
        if (!bus.waitrequest) begin
          write_d     = 1'b0;
          rsp_rdata_d = 32'b0;
          rsp_err_d   = 1'b0;
          state_d     = S_RESP;
        end else if (timeout_hit) begin
          write_d     = 1'b0;
          rsp_rdata_d = 32'b0;
          rsp_err_d   = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        rsp_rdata_d = 32'b0;
        rsp_err_d   = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      address_q    <= 32'b0;
      byteenable_q <= 4'b0;
      h2a_q        <= 32'b0;
      off_q        <= 2'b0;
      size_q       <= 2'b0;
      uns_q        <= 1'b0;
      cnt_q        <= '0;
      rsp_rdata_q  <= 32'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      read_q       <= read_d;
      write_q      <= write_d;
      address_q    <= address_d;
      byteenable_q <= byteenable_d;
      h2a_q        <= h2a_d;
      off_q        <= off_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      cnt_q        <= cnt_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign req_ready          = (state_q == S_IDLE);
  assign rsp_valid          = (state_q == S_RESP);
  assign rsp_rdata          = rsp_rdata_q;
  assign rsp_err            = rsp_err_q;
  assign bus.address        = address_q;
  assign bus.read           = read_q;
  assign bus.write          = write_q;
  assign bus.byteenable     = byteenable_q;
  assign bus.host_to_agent  = h2a_q;

endmodule

// File: tb/tb_lsu_bus_host.sv
// Directed bench for lsu_bus_host against a registered byte-addressed memory agent.
module tb_lsu_bus_host;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        agent_hold;
  logic        rdv_r = 1'b0;
  logic [31:0] a2h_r = 32'b0;
  logic [7:0]  mem [0:1023];

  int          strobe_cnt = 0;
  logic        both_seen  = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;

  logic [31:0] snap_addr;
  logic [3:0]  snap_be;
  logic [31:0] snap_h2a;

  AvalonMmRw bus_if ();

  lsu_bus_host #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .bus          (bus_if)
  );

  always #5 clk = ~clk;

  // Registered agent: writes land on the accepting edge, read data one cycle after read.
  assign bus_if.waitrequest   = agent_hold;
  assign bus_if.readdatavalid = rdv_r;
  assign bus_if.agent_to_host = a2h_r;

  always @(posedge clk) begin
    if (bus_if.write && !agent_hold) begin
      for (int i = 0; i < 4; i++)
        if (bus_if.byteenable[i])
          mem[int'(bus_if.address[9:0]) + i] <= bus_if.host_to_agent[8*i +: 8];
    end
    rdv_r <= bus_if.read && !rdv_r && !agent_hold;
    a2h_r <= {mem[int'(bus_if.address[9:0]) + 3], mem[int'(bus_if.address[9:0]) + 2],
              mem[int'(bus_if.address[9:0]) + 1], mem[int'(bus_if.address[9:0])]};
  end

  always @(negedge clk) begin
    if (bus_if.read || bus_if.write) strobe_cnt <= strobe_cnt + 1;
    if (bus_if.read && bus_if.write) both_seen <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] rd, output logic er, output int st);
    int base;
    @(negedge clk);
    base         = strobe_cnt;
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = u;
    req_addr     = a;
    req_wdata    = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    rd  = 32'b0;
    er  = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) begin
        snap_addr = bus_if.address;
        snap_be   = bus_if.byteenable;
        snap_h2a  = bus_if.host_to_agent;
      end
      if (rsp_valid) begin
        lat = i;
        rd  = rsp_rdata;
        er  = rsp_err;
        break;
      end
    end
    @(negedge clk);
    chk("rsp_one_cycle", {31'b0, rsp_valid}, 32'd0);
    chk("ready_back", {31'b0, req_ready}, 32'd1);
    st = strobe_cnt - base;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          st;
    int          rv_seen;
    logic [31:0] rd;
    logic        er;

    reset_n      = 1'b0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'b0;
    req_wdata    = 32'b0;
    agent_hold   = 1'b0;

    @(negedge clk);
    chk("rst_strobes", {30'b0, bus_if.read, bus_if.write}, 32'd0);
    chk("rst_be", 32'(bus_if.byteenable), 32'd0);
    chk("rst_addr", bus_if.address, 32'd0);
    chk("rst_h2a", bus_if.host_to_agent, 32'd0);
    chk("rst_rsp", {30'b0, rsp_valid, rsp_err}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // Byte store at 0x103, then signed and unsigned loads of it
    issue(1'b1, 2'b00, 1'b0, 32'h103, 32'h0000_00A5, lat, rd, er, st);
    chk("sb_addr", snap_addr, 32'h100);
    chk("sb_be", 32'(snap_be), 32'b1000);
    chk("sb_h2a", snap_h2a, 32'hA500_0000);
    chk("sb_lat", 32'(lat), 32'd2);
    chk("sb_rsp", {rd[30:0], er}, 32'd0);
    chk("sb_strobes", 32'(st), 32'd1);
    issue(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, lat, rd, er, st);
    chk("lb_rdata", rd, 32'hFFFF_FFA5);
    chk("lb_lat", 32'(lat), 32'd3);
    issue(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, lat, rd, er, st);
    chk("lbu_rdata", rd, 32'h0000_00A5);
    chk("lbu_err", {31'b0, er}, 32'd0);

    // Half store/load at offset 2
    issue(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000_8001, lat, rd, er, st);
    chk("sh_be", 32'(snap_be), 32'b1100);
    chk("sh_h2a", snap_h2a, 32'h8001_0000);
    issue(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, lat, rd, er, st);
    chk("lh_rdata", rd, 32'hFFFF_8001);
    issue(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, lat, rd, er, st);
    chk("lhu_rdata", rd, 32'h0000_8001);

    // Word round trip, then byte lanes from inside the word
    issue(1'b1, 2'b10, 1'b0, 32'h200, 32'hDEAD_BEEF, lat, rd, er, st);
    chk("sw_be", 32'(snap_be), 32'b1111);
    chk("sw_h2a", snap_h2a, 32'hDEAD_BEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, lat, rd, er, st);
    chk("lw_rdata", rd, 32'hDEAD_BEEF);
    chk("lw_lat", 32'(lat), 32'd3);
    chk("lw_strobes", 32'(st), 32'd2);
    issue(1'b0, 2'b00, 1'b1, 32'h201, 32'h0, lat, rd, er, st);
    chk("lbu_off1", rd, 32'h0000_00BE);
    issue(1'b0, 2'b00, 1'b0, 32'h201, 32'h0, lat, rd, er, st);
    chk("lb_off1", rd, 32'hFFFF_FFBE);

    // Misaligned and illegal requests never reach the bus
    issue(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, lat, rd, er, st);
    chk("mis_lw", {st[15:0], lat[7:0], rd[6:0], er}, {16'd0, 8'd1, 7'd0, 1'b1});
    issue(1'b1, 2'b01, 1'b0, 32'h103, 32'h1234, lat, rd, er, st);
    chk("mis_sh", {st[15:0], lat[7:0], rd[6:0], er}, {16'd0, 8'd1, 7'd0, 1'b1});
    issue(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, lat, rd, er, st);
    chk("bad_size", {st[15:0], lat[7:0], rd[6:0], er}, {16'd0, 8'd1, 7'd0, 1'b1});
    chk("bad_size_rdata", rd, 32'd0);

    // Timeout: strobe held exactly TIMEOUT cycles, then an error response
    agent_hold = 1'b1;
    issue(1'b1, 2'b10, 1'b0, 32'h300, 32'h1111_2222, lat, rd, er, st);
    chk("to_wr_strobes", 32'(st), 32'd4);
    chk("to_wr_lat", 32'(lat), 32'd5);
    chk("to_wr_err", {31'b0, er}, 32'd1);
    issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, lat, rd, er, st);
    chk("to_rd_strobes", 32'(st), 32'd4);
    chk("to_rd_rsp", {rd[30:0], er}, 32'd1);

    // Asynchronous reset while read is high
    @(negedge clk);
    req_valid    = 1'b1;
    req_write    = 1'b0;
    req_size     = 2'b10;
    req_unsigned = 1'b0;
    req_addr     = 32'h200;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("mid_read_on", {31'b0, bus_if.read}, 32'd1);
    #2 reset_n = 1'b0;
    #1 chk("mid_read_drop", {31'b0, bus_if.read}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n    = 1'b1;
    agent_hold = 1'b0;
    rv_seen    = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) rv_seen++;
    end
    chk("mid_read_no_rsp", 32'(rv_seen), 32'd0);
    issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, lat, rd, er, st);
    chk("post_rst_lw", rd, 32'hDEAD_BEEF);
    chk("post_rst_lat", 32'(lat), 32'd3);

    chk("never_both", {31'b0, both_seen}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_bus_host.md
# lsu_bus_host

Avalon-MM host-side bus initiator that turns single CPU load/store requests into one read or write on an `AvalonMmRw` bus. It drives the same byte-enabled bus that the memory agents answer, performs lane steering and load sign/zero extension, and rejects misaligned or illegal accesses without touching the bus. It sits between the core's load/store stage and the data bus, and has at most one transaction in flight.

## Interface
- `TIMEOUT`, default 256: cycles a strobe may stay asserted without completing before the transaction is aborted with an error; 0 disables the timeout.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request; high only in IDLE.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_unsigned` in 1: load zero-extends when 1 and sign-extends when 0; ignored for stores.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, LSB-aligned.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_err` out 1: qualifies `rsp_valid`; set for misaligned, illegal-size or timeout.
- `bus` modport `AvalonMmRw.Host`: drives `address`, `read`, `write`, `byteenable`, `host_to_agent`; samples `agent_to_host`, `waitrequest`, `readdatavalid`.

## Operation
- **States:** IDLE, READ, WRITE, RESP.
- **Accept:** `req_valid && req_ready` in IDLE.
- **Alignment and size check at accept:**
  - Misaligned means a half with `addr[0]=1`, or a word with `addr[1:0]!=0`.
  - A misaligned access or `req_size=11` goes straight to RESP with `rsp_err=1`. No strobe is issued.
- **Legal access at accept:**
  - `address = {req_addr[31:2],2'b00}`.
  - `byteenable` = 0001 for a byte, 0011 for a half, 1111 for a word, each shifted left by `addr[1:0]`.
  - `host_to_agent = req_wdata << (8*addr[1:0])`.
  - Go to WRITE if `req_write`, otherwise READ.
- **Bus signals hold:** `address`, `byteenable` and `host_to_agent` are held constant while `read` or `write` is high.
- **READ:**
  - `read=1`.
  - Completes on the first cycle with `readdatavalid=1`.
  - On completion, lane = `agent_to_host >> (8*addr[1:0])`. Extend bits 7 (byte) or 15 (half) per `req_unsigned`. A word is passed through unchanged.
  - Then go to RESP.
- **WRITE:**
  - `write=1`.
  - Completes on the first cycle with `waitrequest=0`, then go to RESP.
- **Timeout:**
  - A counter clears on entry to READ/WRITE and increments every cycle the transaction is not complete.
  - When the counter reaches `TIMEOUT` (if nonzero), drop the strobe, go to RESP with `rsp_err=1` and `rsp_rdata=0`.
- **RESP:** `rsp_valid=1` for exactly one cycle, then IDLE.
- **Stale `readdatavalid`:** ignored in every state except READ.
- **Strobes:** `read` and `write` are never high together.
- **Reset values:** state IDLE, `read=0`, `write=0`, `byteenable=0`, `address=0`, `host_to_agent=0`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, counter 0.
- **Reset mid-transaction:** strobes drop immediately; no response is produced for the aborted transaction.

## Timing
- **Load:**
  - Request accepted in cycle T.
  - `read` is high from T+1.
  - Against a registered agent, `readdatavalid` arrives at T+2.
  - `rsp_valid` at T+3.
  - `req_ready` high again at T+4.
- **Store:**
  - Accepted in cycle T; `write` high at T+1.
  - Against a zero-wait agent, it completes at T+1.
  - `rsp_valid` at T+2 and `req_ready` at T+3.
- **Error:**
  - Accepted in cycle T; `rsp_valid` with `rsp_err=1` at T+1.
  - No bus activity.
- **Wait states:** each extra `waitrequest` (write) or late `readdatavalid` (read) cycle adds one cycle of latency.
- **Timeout boundary:** with `TIMEOUT=N` and the agent never answering, the strobe is high for exactly N cycles. `rsp_err` pulses in the following cycle.
- **Back-to-back:** minimum spacing between accepted requests is one idle cycle after RESP. The earliest following strobe comes at least 2 cycles after the previous strobe dropped.

## Test plan
- **Store byte then load:**
  - Stimulus: store byte `0xA5` to `0x103`. Expect `address=0x100`, `byteenable=1000`, `host_to_agent=0xA5000000`, completion at T+2.
  - Stimulus: load the same byte signed. Expect `rsp_rdata=0xFFFFFFA5`. Unsigned expects `0x000000A5`.
- **Half store and load at offset 2:**
  - Stimulus: store half `0x8001` to `0x102`. Expect `byteenable=1100`.
  - Stimulus: signed load. Expect `0xFFFF8001`. Unsigned expects `0x00008001`.
- **Word round trip:**
  - Stimulus: store `0xDEADBEEF` to `0x200`, then load it.
  - Expect `byteenable=1111`, load `rsp_rdata=0xDEADBEEF`, `rsp_valid` exactly at T+3.
- **Misaligned and illegal requests:**
  - Stimulus: word load at `0x101`, half store at `0x103`, and `req_size=11`.
  - Expect each to give `rsp_err=1` at T+1, with `read` and `write` never asserted.
- **Timeout:**
  - Stimulus: `TIMEOUT=4`, agent holds `waitrequest=1` on a write.
  - Expect `write` high for 4 cycles, then `rsp_err=1`, then IDLE.
- **Async reset mid-read:**
  - Stimulus: `reset_n` low while `read=1`.
  - Expect `read`=0 immediately, no `rsp_valid`, and a normal load succeeding after release.
